// File: rtl/tt_sweep_pkg.sv
// Shared types for the truth-table sweep controller: FSM encoding and table-width helper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Number of rows in the truth table of an n-input function.
    function automatic int tw(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times how long each input vector is held before sampling.
module tt_settle_timer #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          expired_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 2**N_IN input vectors through a combinational function, builds its truth table
// and compares it against a golden word. Define TT_MISMATCH_EN for mismatch count/first-bad outputs.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [tw(N_IN)-1:0]   golden,
    input  logic                  f_in,
    output logic [N_IN-1:0]       vec_out,
    output logic                  busy,
    output logic                  done,
    output logic [tw(N_IN)-1:0]   table_out,
    output logic                  pass
`ifdef TT_MISMATCH_EN
    ,
    output logic [N_IN:0]         mism_cnt,
    output logic [N_IN-1:0]       first_bad
`endif
);

    localparam int              TW       = tw(N_IN);
    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(TW - 1);
    localparam logic [CW-1:0]   HOLD_VAL = CW'(SETTLE - 1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q;
    logic [TW-1:0]   scratch_q;
    logic [TW-1:0]   golden_q;
    logic [TW-1:0]   table_q;
    logic            pass_q;
    logic            tmr_load, tmr_dec, tmr_expired;
    logic            accept, last_vec;

    tt_settle_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (HOLD_VAL),
        .dec_i      (tmr_dec),
        .expired_o  (tmr_expired)
    );

    assign accept   = (state_q == ST_IDLE) && start;
    assign last_vec = (vec_q == VEC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    tmr_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (tmr_expired) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (last_vec) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_DRIVE;
                    tmr_load = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q     <= '0;
            scratch_q <= '0;
            golden_q  <= '0;
            table_q   <= '0;
            pass_q    <= 1'b0;
        end else begin
            if (accept) begin
                golden_q  <= golden;
                vec_q     <= '0;
                scratch_q <= '0;
            end
            if (state_q == ST_SAMPLE) begin
                scratch_q[vec_q] <= f_in;
                if (!last_vec) begin
                    vec_q <= vec_q + 1'b1;
                end
            end
            if (state_q == ST_DONE) begin
                table_q <= scratch_q;
                pass_q  <= (scratch_q == golden_q);
            end
        end
    end

    // Vector is only driven while a sweep is actually exercising the datapath.
    assign vec_out   = ((state_q == ST_DRIVE) || (state_q == ST_SAMPLE)) ? vec_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign table_out = table_q;
    assign pass      = pass_q;

`ifdef TT_MISMATCH_EN
    logic [TW-1:0]   diff;
    logic [N_IN:0]   mism_d, mism_q;
    logic [N_IN-1:0] first_d, first_q;
    logic            found;

    // Scan from the top so the last hit written is the lowest mismatching index.
    always_comb begin
        diff    = scratch_q ^ golden_q;
        mism_d  = '0;
        first_d = '0;
        found   = 1'b0;
        for (int i = TW - 1; i >= 0; i--) begin
            if (diff[i]) begin
                mism_d  = mism_d + 1'b1;
                first_d = N_IN'(i);
                found   = 1'b1;
            end
        end
        if (!found) begin
            first_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mism_q  <= '0;
            first_q <= '0;
        end else if (state_q == ST_DONE) begin
            mism_q  <= mism_d;
            first_q <= first_d;
        end
    end

    assign mism_cnt  = mism_q;
    assign first_bad = first_q;
`endif

endmodule
